// File: rtl/nexys_video_gpio.sv
// AXI4-Lite GPIO slave for the Nexys Video board: LEDs, switches and
// five push-button press counters with optional clear-on-read.
module nexys_video_gpio (
   input  logic        s_axi_aclk,
   input  logic        s_axi_aresetn,
   input  logic [31:0] s_axi_awaddr,
   input  logic [2:0]  s_axi_awprot,
   input  logic        s_axi_awvalid,
   output logic        s_axi_awready,
   input  logic [31:0] s_axi_wdata,
   input  logic [3:0]  s_axi_wstrb,
   input  logic        s_axi_wvalid,
   output logic        s_axi_wready,
   output logic [1:0]  s_axi_bresp,
   output logic        s_axi_bvalid,
   input  logic        s_axi_bready,
   input  logic [31:0] s_axi_araddr,
   input  logic [2:0]  s_axi_arprot,
   input  logic        s_axi_arvalid,
   output logic        s_axi_arready,
   output logic [31:0] s_axi_rdata,
   output logic [1:0]  s_axi_rresp,
   output logic        s_axi_rvalid,
   input  logic        s_axi_rready,
   input  logic [7:0]  sw,
   output logic [7:0]  led,
   input  logic        btnc,
   input  logic        btnd,
   input  logic        btnl,
   input  logic        btnu,
   input  logic        btnr
);

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   logic [7:0]  sw_s1_q, sw_s2_q;
   logic [4:0]  btn_s1_q, btn_s2_q, btn_s3_q;
   logic [4:0]  btn_pin, btn_rise;

   logic [4:0]  cfg_q, cfg_d;
   logic [7:0]  led_q, led_d;
   logic        bvalid_q, bvalid_d;
   logic [1:0]  bresp_q, bresp_d;
   logic        rvalid_q, rvalid_d;
   logic [1:0]  rresp_q, rresp_d;
   logic [31:0] rdata_q, rdata_d;
   logic [31:0] cnt_q [5];
   logic [31:0] cnt_d [5];

   logic        wr_fire, rd_fire, w_bad, r_bad, clr;
   logic [5:0]  waddr, raddr;
   logic [2:0]  widx, ridx;
   logic [31:0] rd_val;
   logic        unused;

   assign unused = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr[31:6],
                     s_axi_araddr[31:6], s_axi_wdata[31:8]};

   assign btn_pin  = {btnr, btnu, btnl, btnd, btnc};
   assign btn_rise = btn_s2_q & ~btn_s3_q;

   assign waddr = s_axi_awaddr[5:0];
   assign raddr = s_axi_araddr[5:0];
   assign widx  = waddr[4:2];
   assign ridx  = raddr[4:2];

   assign wr_fire = s_axi_awvalid && s_axi_wvalid && !bvalid_q && s_axi_aresetn;
   assign rd_fire = s_axi_arvalid && !rvalid_q && s_axi_aresetn;

   assign w_bad = (waddr[1:0] != 2'b00) || (waddr > 6'h1C) || (waddr == 6'h08);
   assign r_bad = (raddr[1:0] != 2'b00) || (raddr > 6'h1C);

   assign s_axi_awready = wr_fire;
   assign s_axi_wready  = wr_fire;
   assign s_axi_arready = !rvalid_q && s_axi_aresetn;
   assign s_axi_bvalid  = bvalid_q;
   assign s_axi_bresp   = bresp_q;
   assign s_axi_rvalid  = rvalid_q;
   assign s_axi_rresp   = rresp_q;
   assign s_axi_rdata   = rdata_q;
   assign led           = led_q;

   always_comb begin
      case (ridx)
         3'd0:    rd_val = {27'b0, cfg_q};
         3'd1:    rd_val = {24'b0, led_q};
         3'd2:    rd_val = {24'b0, sw_s2_q};
         3'd3:    rd_val = cnt_q[0];
         3'd4:    rd_val = cnt_q[1];
         3'd5:    rd_val = cnt_q[2];
         3'd6:    rd_val = cnt_q[3];
         default: rd_val = cnt_q[4];
      endcase
   end

   always_comb begin
      cfg_d    = cfg_q;
      led_d    = led_q;
      bvalid_d = bvalid_q;
      bresp_d  = bresp_q;
      rvalid_d = rvalid_q;
      rresp_d  = rresp_q;
      rdata_d  = rdata_q;
      clr      = 1'b0;
      if (bvalid_q && s_axi_bready) bvalid_d = 1'b0;
      if (rvalid_q && s_axi_rready) rvalid_d = 1'b0;
      if (wr_fire) begin
         bvalid_d = 1'b1;
         bresp_d  = w_bad ? RESP_SLVERR : RESP_OKAY;
         if (!w_bad && s_axi_wstrb[0]) begin
            if (widx == 3'd0) cfg_d = s_axi_wdata[4:0];
            if (widx == 3'd1) led_d = s_axi_wdata[7:0];
         end
      end
      if (rd_fire) begin
         rvalid_d = 1'b1;
         rresp_d  = r_bad ? RESP_SLVERR : RESP_OKAY;
         rdata_d  = r_bad ? 32'b0 : rd_val;
      end
      // A clear that coincides with a press edge leaves the count at 1
      for (int k = 0; k < 5; k++) begin
         clr = (wr_fire && !w_bad && widx == 3'(k + 3) && |s_axi_wstrb)
            || (rd_fire && !r_bad && ridx == 3'(k + 3) && cfg_q[k]);
         if (clr) cnt_d[k] = {31'b0, btn_rise[k]};
         else     cnt_d[k] = cnt_q[k] + {31'b0, btn_rise[k]};
      end
   end

   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
         sw_s1_q  <= '0;
         sw_s2_q  <= '0;
         btn_s1_q <= '0;
         btn_s2_q <= '0;
         btn_s3_q <= '0;
         cfg_q    <= '0;
         led_q    <= '0;
         bvalid_q <= 1'b0;
         bresp_q  <= RESP_OKAY;
         rvalid_q <= 1'b0;
         rresp_q  <= RESP_OKAY;
         rdata_q  <= '0;
         for (int k = 0; k < 5; k++) cnt_q[k] <= '0;
      end else begin
         sw_s1_q  <= sw;
         sw_s2_q  <= sw_s1_q;
         btn_s1_q <= btn_pin;
         btn_s2_q <= btn_s1_q;
         btn_s3_q <= btn_s2_q;
         cfg_q    <= cfg_d;
         led_q    <= led_d;
         bvalid_q <= bvalid_d;
         bresp_q  <= bresp_d;
         rvalid_q <= rvalid_d;
         rresp_q  <= rresp_d;
         rdata_q  <= rdata_d;
         for (int k = 0; k < 5; k++) cnt_q[k] <= cnt_d[k];
      end
   end

endmodule

// File: tb/tb_nexys_video_gpio.sv
// Directed self-checking bench for nexys_video_gpio.
module tb_nexys_video_gpio;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] awaddr, wdata, araddr;
   logic [3:0]  wstrb;
   logic        awvalid, wvalid, bready, arvalid, rready;
   logic        awready, wready, bvalid, arready, rvalid;
   logic [1:0]  bresp, rresp;
   logic [31:0] rdata;
   logic [7:0]  sw, led;
   logic [4:0]  btn;

   int errors = 0;
   int checks = 0;
   logic [31:0] rd_data;
   logic [1:0]  rd_resp, wr_resp;

   always #5 clk = ~clk;

   nexys_video_gpio dut (
      .s_axi_aclk(clk), .s_axi_aresetn(rst_n),
      .s_axi_awaddr(awaddr), .s_axi_awprot(3'b000),
      .s_axi_awvalid(awvalid), .s_axi_awready(awready),
      .s_axi_wdata(wdata), .s_axi_wstrb(wstrb),
      .s_axi_wvalid(wvalid), .s_axi_wready(wready),
      .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
      .s_axi_araddr(araddr), .s_axi_arprot(3'b000),
      .s_axi_arvalid(arvalid), .s_axi_arready(arready),
      .s_axi_rdata(rdata), .s_axi_rresp(rresp),
      .s_axi_rvalid(rvalid), .s_axi_rready(rready),
      .sw(sw), .led(led),
      .btnc(btn[0]), .btnd(btn[1]), .btnl(btn[2]),
      .btnu(btn[3]), .btnr(btn[4])
   );

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic axi_write(input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, output logic [1:0] resp);
      int n;
      awaddr = a; wdata = d; wstrb = s;
      awvalid = 1'b1; wvalid = 1'b1;
      #1;
      n = 0;
      while (!awready && n < 20) begin
         tick(1);
         n++;
      end
      if (!awready) begin
         checks++; errors++;
         $display("FAIL wr_timeout addr=%h awready=%b exp=1", a, awready);
         awvalid = 1'b0; wvalid = 1'b0;
         resp = 2'bxx;
      end else begin
         tick(1);
         awvalid = 1'b0; wvalid = 1'b0;
         resp = bresp;
         checks++;
         if (bvalid !== 1'b1) begin
            errors++;
            $display("FAIL wr_bvalid addr=%h got=%b exp=1", a, bvalid);
         end
         bready = 1'b1;
         tick(1);
         bready = 1'b0;
      end
   endtask

   task automatic axi_read(input logic [31:0] a, output logic [31:0] d,
                           output logic [1:0] resp);
      int n;
      araddr = a; arvalid = 1'b1;
      #1;
      n = 0;
      while (!arready && n < 20) begin
         tick(1);
         n++;
      end
      if (!arready) begin
         checks++; errors++;
         $display("FAIL rd_timeout addr=%h arready=%b exp=1", a, arready);
         arvalid = 1'b0;
         d = 'x; resp = 2'bxx;
      end else begin
         tick(1);
         arvalid = 1'b0;
         d = rdata; resp = rresp;
         checks++;
         if (rvalid !== 1'b1) begin
            errors++;
            $display("FAIL rd_latency addr=%h rvalid=%b exp=1", a, rvalid);
         end
         rready = 1'b1;
         tick(1);
         rready = 1'b0;
      end
   endtask

   task automatic pulse(input int idx, input int n);
      repeat (n) begin
         btn[idx] = 1'b1;
         tick(2);
         btn[idx] = 1'b0;
         tick(2);
      end
      tick(4);
   endtask

   task automatic test_reset();
      awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
      #1;
      checks++;
      if ({awready, wready, arready} !== 3'b000) begin
         errors++;
         $display("FAIL reset_ready got=%b exp=000", {awready, wready, arready});
      end
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      checks++;
      if ({bvalid, rvalid, led, rdata} !== '0) begin
         errors++;
         $display("FAIL reset_state bv=%b rv=%b led=%h rdata=%h exp=0",
                  bvalid, rvalid, led, rdata);
      end
      @(negedge clk);
      rst_n = 1'b1;
      tick(2);
   endtask

   task automatic test_sw();
      sw = 8'h2A;
      tick(3);
      axi_read(32'h08, rd_data, rd_resp);
      checks++;
      if (rd_data !== 32'h2A || rd_resp !== 2'b00) begin
         errors++;
         $display("FAIL sw_read got=%h/%b exp=0000002a/00", rd_data, rd_resp);
      end
      sw = 8'h55;
      axi_read(32'h08, rd_data, rd_resp);
      checks++;
      if (rd_data !== 32'h2A) begin
         errors++;
         $display("FAIL sw_latency got=%h exp=0000002a", rd_data);
      end
      axi_read(32'h08, rd_data, rd_resp);
      checks++;
      if (rd_data !== 32'h55) begin
         errors++;
         $display("FAIL sw_update got=%h exp=00000055", rd_data);
      end
   endtask

   task automatic test_buttons();
      pulse(0, 5);
      axi_read(32'h0C, rd_data, rd_resp);
      checks++;
      if (rd_data !== 32'd5 || rd_resp !== 2'b00) begin
         errors++;
         $display("FAIL btnc_count got=%h/%b exp=5/00", rd_data, rd_resp);
      end
      axi_read(32'h10, rd_data, rd_resp);
      checks++;
      if (rd_data !== 32'd0) begin
         errors++;
         $display("FAIL btnd_idle got=%h exp=0", rd_data);
      end
   endtask

   task automatic test_led();
      axi_write(32'h04, 32'hA5, 4'hF, wr_resp);
      checks++;
      if (wr_resp !== 2'b00 || led !== 8'hA5) begin
         errors++;
         $display("FAIL led_write got=%b/%h exp=00/a5", wr_resp, led);
      end
      axi_read(32'h04, rd_data, rd_resp);
      checks++;
      if (rd_data !== 32'hA5) begin
         errors++;
         $display("FAIL led_readback got=%h exp=000000a5", rd_data);
      end
      axi_write(32'h04, 32'h3C, 4'h0, wr_resp);
      checks++;
      if (wr_resp !== 2'b00 || led !== 8'hA5) begin
         errors++;
         $display("FAIL led_strb0 got=%b/%h exp=00/a5", wr_resp, led);
      end
      axi_write(32'h04, 32'hFF, 4'h2, wr_resp);
      checks++;
      if (wr_resp !== 2'b00 || led !== 8'hA5) begin
         errors++;
         $display("FAIL led_strb_hi got=%b/%h exp=00/a5", wr_resp, led);
      end
   endtask

   task automatic test_errors();
      axi_write(32'h08, 32'hFF, 4'hF, wr_resp);
      checks++;
      if (wr_resp !== 2'b10) begin
         errors++;
         $display("FAIL wr_sw_err got=%b exp=10", wr_resp);
      end
      axi_read(32'h08, rd_data, rd_resp);
      checks++;
      if (rd_data !== 32'h55 || rd_resp !== 2'b00) begin
         errors++;
         $display("FAIL sw_after_err got=%h/%b exp=55/00", rd_data, rd_resp);
      end
      axi_read(32'h09, rd_data, rd_resp);
      checks++;
      if (rd_data !== 32'h0 || rd_resp !== 2'b10) begin
         errors++;
         $display("FAIL rd_unaligned got=%h/%b exp=0/10", rd_data, rd_resp);
      end
      axi_read(32'h20, rd_data, rd_resp);
      checks++;
      if (rd_data !== 32'h0 || rd_resp !== 2'b10) begin
         errors++;
         $display("FAIL rd_range got=%h/%b exp=0/10", rd_data, rd_resp);
      end
      axi_read(32'h1C, rd_data, rd_resp);
      checks++;
      if (rd_data !== 32'h0 || rd_resp !== 2'b00) begin
         errors++;
         $display("FAIL rd_last_reg got=%h/%b exp=0/00", rd_data, rd_resp);
      end
      axi_write(32'h05, 32'h11, 4'hF, wr_resp);
      checks++;
      if (wr_resp !== 2'b10 || led !== 8'hA5) begin
         errors++;
         $display("FAIL wr_unaligned got=%b/%h exp=10/a5", wr_resp, led);
      end
      axi_write(32'h20, 32'h11, 4'hF, wr_resp);
      checks++;
      if (wr_resp !== 2'b10) begin
         errors++;
         $display("FAIL wr_range got=%b exp=10", wr_resp);
      end
   endtask

   task automatic test_clear_on_read();
      axi_write(32'h00, 32'hFFFF_FFE1, 4'h1, wr_resp);
      axi_read(32'h00, rd_data, rd_resp);
      checks++;
      if (rd_data !== 32'h01) begin
         errors++;
         $display("FAIL cfg_read got=%h exp=00000001", rd_data);
      end
      axi_read(32'h0C, rd_data, rd_resp);
      checks++;
      if (rd_data !== 32'd5) begin
         errors++;
         $display("FAIL cor_first got=%h exp=5", rd_data);
      end
      pulse(0, 3);
      axi_read(32'h0C, rd_data, rd_resp);
      checks++;
      if (rd_data !== 32'd3) begin
         errors++;
         $display("FAIL cor_count got=%h exp=3", rd_data);
      end
      axi_read(32'h0C, rd_data, rd_resp);
      checks++;
      if (rd_data !== 32'd0) begin
         errors++;
         $display("FAIL cor_cleared got=%h exp=0", rd_data);
      end
   endtask

   task automatic test_write_clear();
      pulse(1, 2);
      btn[1] = 1'b1;
      tick(2);
      axi_write(32'h0C, 32'h0, 4'hF, wr_resp);
      btn[1] = 1'b0;
      tick(4);
      axi_read(32'h10, rd_data, rd_resp);
      checks++;
      if (rd_data !== 32'd3) begin
         errors++;
         $display("FAIL btnd_unaffected got=%h exp=3", rd_data);
      end
      axi_write(32'h10, 32'h0, 4'h0, wr_resp);
      axi_read(32'h10, rd_data, rd_resp);
      checks++;
      if (rd_data !== 32'd3) begin
         errors++;
         $display("FAIL clr_strb0 got=%h exp=3", rd_data);
      end
      axi_write(32'h10, 32'h0, 4'h4, wr_resp);
      axi_read(32'h10, rd_data, rd_resp);
      checks++;
      if (rd_data !== 32'd0) begin
         errors++;
         $display("FAIL clr_strb_hi got=%h exp=0", rd_data);
      end
      pulse(2, 2);
      btn[2] = 1'b1;
      tick(2);
      axi_write(32'h14, 32'h0, 4'hF, wr_resp);
      btn[2] = 1'b0;
      tick(4);
      axi_read(32'h14, rd_data, rd_resp);
      checks++;
      if (rd_data !== 32'd1) begin
         errors++;
         $display("FAIL clr_and_edge got=%h exp=1", rd_data);
      end
   endtask

   task automatic test_back_to_back();
      araddr = 32'h04; arvalid = 1'b1;
      awaddr = 32'h04; wdata = 32'h5A; wstrb = 4'hF;
      awvalid = 1'b1; wvalid = 1'b1;
      tick(1);
      arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
      checks++;
      if (rvalid !== 1'b1 || rdata !== 32'hA5 || led !== 8'h5A) begin
         errors++;
         $display("FAIL rw_same_cycle rv=%b rdata=%h led=%h exp=1/a5/5a",
                  rvalid, rdata, led);
      end
      rready = 1'b1; bready = 1'b1;
      tick(1);
      rready = 1'b0; bready = 1'b0;
      wdata = 32'h11; awvalid = 1'b1; wvalid = 1'b1;
      tick(1);
      wdata = 32'h22;
      for (int i = 0; i < 3; i++) begin
         tick(1);
         checks++;
         if (awready !== 1'b0 || bvalid !== 1'b1 || led !== 8'h11) begin
            errors++;
            $display("FAIL stall[%0d] awready=%b bvalid=%b led=%h exp=0/1/11",
                     i, awready, bvalid, led);
         end
      end
      bready = 1'b1;
      tick(1);
      bready = 1'b0;
      checks++;
      if (bvalid !== 1'b0 || awready !== 1'b1) begin
         errors++;
         $display("FAIL stall_release bvalid=%b awready=%b exp=0/1",
                  bvalid, awready);
      end
      tick(1);
      awvalid = 1'b0; wvalid = 1'b0;
      checks++;
      if (bvalid !== 1'b1 || led !== 8'h22) begin
         errors++;
         $display("FAIL second_write bvalid=%b led=%h exp=1/22", bvalid, led);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (bvalid !== 1'b0 || led !== 8'h00 || awready !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid bvalid=%b led=%h awready=%b exp=0/00/0",
                  bvalid, led, awready);
      end
      @(negedge clk);
      rst_n = 1'b1;
      tick(2);
      axi_read(32'h00, rd_data, rd_resp);
      checks++;
      if (rd_data !== 32'h0) begin
         errors++;
         $display("FAIL cfg_after_reset got=%h exp=0", rd_data);
      end
      axi_read(32'h10, rd_data, rd_resp);
      checks++;
      if (rd_data !== 32'h0) begin
         errors++;
         $display("FAIL cnt_after_reset got=%h exp=0", rd_data);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      awaddr = '0; wdata = '0; wstrb = '0; araddr = '0;
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      bready = 1'b0; rready = 1'b0;
      sw = '0; btn = '0;
      tick(2);
      test_reset();
      test_sw();
      test_buttons();
      test_led();
      test_errors();
      test_clear_on_read();
      test_write_clear();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/nexys_video_gpio.md
# nexys_video_gpio

AXI4-Lite slave exposing Nexys Video board I/O to a processor: 8 LEDs (read/write), 8 slide switches (read-only) and five push-buttons, each with a 32-bit rising-edge press counter. It sits on the system AXI-Lite interconnect as a leaf peripheral and drives and samples the board pins directly.

## Interface
- No parameters. Data width is fixed at 32 bits; address ports are 32 bits and only addr[5:0] is decoded.
- s_axi_aclk  in  1  the block's single clock; all logic is on its rising edge.
- s_axi_aresetn  in  1  reset, asynchronous and active-low.
- s_axi_awaddr  in  32  write address. s_axi_awprot  in  3  ignored.
- s_axi_awvalid  in  1 / s_axi_awready  out  1  write address handshake.
- s_axi_wdata  in  32 / s_axi_wstrb  in  4  write data and byte strobes.
- s_axi_wvalid  in  1 / s_axi_wready  out  1  write data handshake.
- s_axi_bresp  out  2 / s_axi_bvalid  out  1 / s_axi_bready  in  1  write response.
- s_axi_araddr  in  32. s_axi_arprot  in  3  ignored.
- s_axi_arvalid  in  1 / s_axi_arready  out  1  read address handshake.
- s_axi_rdata  out  32 / s_axi_rresp  out  2 / s_axi_rvalid  out  1 / s_axi_rready  in  1  read data.
- sw  in  8  slide switches, asynchronous.
- led  out  8  LED drive, equal to the LED register.
- btnc, btnd, btnl, btnu, btnr  in  1 each  push-buttons, asynchronous, active-high.

## Operation
- Register map (byte offsets, word aligned):
  - 0x00 CONFIG: RW, bits[4:0]; all other bits read 0.
  - 0x04 LED: RW, bits[7:0].
  - 0x08 SW: RO, {24'b0, synchronized sw}.
  - 0x0C BTNC, 0x10 BTND, 0x14 BTNL, 0x18 BTNU, 0x1C BTNR: 32-bit press counters.
- CONFIG bit n enables clear-on-read for the counter with index n. Order: 0 = C, 1 = D, 2 = L, 3 = U, 4 = R. Reset value is 0, so counters are free-running by default.
- Buttons and switches each pass through a 2-flop synchronizer. No debouncing.
- A counter increments by 1 on each synchronized 0->1 transition of its button. It wraps from 0xFFFFFFFF to 0.
- A write to a counter offset clears that counter, provided wstrb is non-zero.
- A read of a counter whose CONFIG bit is set returns the current value, then clears the counter.
- If a clear and a press edge occur in the same cycle, the counter becomes 1.
- Byte-lane writes:
  - CONFIG and LED are updated only when wstrb[0]=1.
  - Other strobe bits have no effect.
  - Any response is still OKAY.
- Error responses: SLVERR (2'b10) with no side effects for:
  - a write to SW (0x08);
  - any access with addr[1:0] != 0;
  - any access with addr[5:0] > 0x1C.
- On a read error, rdata = 0. All other accesses return OKAY (2'b00).

## Timing
- Reset values: awready=wready=arready=0 while reset is asserted; bvalid=rvalid=0, bresp=rresp=0, rdata=0, led=0, CONFIG=0, all counters=0, synchronizers=0.
- Write channel:
  - awready and wready are asserted together, combinationally, when awvalid && wvalid && !bvalid.
  - Address and data are therefore accepted in the same cycle. A lone awvalid or wvalid waits.
  - The register update and bvalid=1 take effect on the accepting edge.
  - bvalid is held until a cycle with bready=1; no new write is accepted meanwhile.
- Read channel:
  - arready = !rvalid, combinationally.
  - On the edge where arvalid && arready, rdata and rresp are registered and rvalid is set.
  - Read latency is 1 cycle. rvalid and rdata are held until rready=1.
- A read and a write in the same cycle are both serviced. The read returns the pre-write value.
- Pin latency:
  - sw change -> visible in SW reads 2 cycles later.
  - Button rising edge at the pin -> counter incremented 3 edges later.
  - A 2-cycle-high, 2-cycle-low button pulse train counts every pulse.
- LED register -> led pin: combinational from the register, no extra delay.
- Reset asserted mid-transaction: any pending response is dropped and all state returns to reset values.

## Test plan
- sw=0x2A, read 0x08 with rready=1 -> rvalid 1 cycle after the handshake, rdata=0x0000002A, rresp=OKAY.
- Pulse btnc five times (2 cycles high / 2 cycles low), then read 0x0C -> rdata=5. Reading BTND returns 0.
- Write 0xA5 to 0x04 with wstrb=0xF -> bvalid next cycle with OKAY, led=0xA5, read-back of 0x04 = 0x000000A5. Repeat with wstrb=0 -> led unchanged.
- Write to 0x08 -> bresp=SLVERR, SW reads unaffected. Read 0x09 -> rresp=SLVERR, rdata=0. Read 0x20 -> SLVERR.
- Write CONFIG=0x01, press btnc 3 times, read 0x0C twice -> 3, then 0. Write 0x0C with btnd pressed -> BTND count unaffected.
- Hold bready=0 after a write -> bvalid stays 1 and a second write is stalled until bready=1. Assert reset mid-response -> bvalid=0, led=0.
